alu_operate_sequencer: RTL and testbench

Multi-cycle LC-3 operate-instruction controller that drives the 16-bit ALU from the initiator side. It accepts ADD/AND/NOT instructions over a valid/ready handshake and owns the 8×16 general-purpose register file. It reads source operands, presents them and the ALU select code, captures the ALU result, writes the destination register and updates the NZP condition codes. It sits between the instruction decode path and the ALU; the ALU itself stays combinational and external.

---
 rtl/alu_operate_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_operate_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operate_sequencer.sv
// LC-3 ADD/AND/NOT sequencer owning the 8x16 register file; legal ops take 4 cycles (IDLE-READ-EXEC-WRITE).
// Illegal opcodes take 2 cycles; instr_ready is low while busy and while an external load is pending.
module alu_operate_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        ext_wr_en,
  input  logic [2:0]  ext_wr_addr,
  input  logic [15:0] ext_wr_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [1:0]  alu_select,
  output logic [15:0] alu_in_a,
  output logic [15:0] alu_in_b,
  input  logic [15:0] alu_out,
  output logic [2:0]  nzp,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_ILLEGAL
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  state_t      state, next_state;
  logic [15:0] rf [8];
  logic [15:0] instr_q;
  logic [15:0] result_q;
  logic        in_legal;
  logic [15:0] b_operand;
  logic [1:0]  sel_dec;

  // Opcode of the word being offered decides the branch out of IDLE.
  assign in_legal = (instr[15:12] == OP_ADD) || (instr[15:12] == OP_AND) ||
                    (instr[15:12] == OP_NOT);

  always_comb begin
    b_operand = 16'h0000;
    sel_dec   = 2'b00;
    case (instr_q[15:12])
      OP_AND: sel_dec = 2'b10;
      OP_NOT: sel_dec = 2'b01;
      default: sel_dec = 2'b00;
    endcase
    if (instr_q[15:12] != OP_NOT) begin
      if (instr_q[5]) b_operand = {{11{instr_q[4]}}, instr_q[4:0]};
      else            b_operand = rf[instr_q[2:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = !ext_wr_en;
        if (instr_valid && !ext_wr_en) next_state = in_legal ? S_READ : S_ILLEGAL;
      end
      S_READ:    next_state = S_EXEC;
      S_EXEC:    next_state = S_WRITE;
      S_WRITE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        next_state = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      instr_q    <= 16'h0000;
      result_q   <= 16'h0000;
      alu_in_a   <= 16'h0000;
      alu_in_b   <= 16'h0000;
      alu_select <= 2'b00;
      nzp        <= 3'b010;
    end else begin
      case (state)
        S_IDLE: begin
          if (ext_wr_en) rf[ext_wr_addr] <= ext_wr_data;
          else if (instr_valid) instr_q <= instr;
        end
        S_READ: begin
          alu_in_a   <= rf[instr_q[8:6]];
          alu_in_b   <= b_operand;
          alu_select <= sel_dec;
        end
        S_EXEC: result_q <= alu_out;
        S_WRITE: begin
          rf[instr_q[11:9]] <= result_q;
          if (result_q[15])             nzp <= 3'b100;
          else if (result_q == 16'h0000) nzp <= 3'b010;
          else                          nzp <= 3'b001;
        end
        default: ;
      endcase
    end
  end

  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_operate_sequencer.sv
// Directed and randomized checks of alu_operate_sequencer against an instruction-level model.
module tb_alu_operate_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        ext_wr_en;
  logic [2:0]  ext_wr_addr;
  logic [15:0] ext_wr_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [1:0]  alu_select;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [15:0] alu_out;
  logic [2:0]  nzp;
  logic        done;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_rf [8];
  logic [2:0]  m_nzp;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_sel;

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    case (alu_select)
      2'b00:   alu_out = alu_in_a + alu_in_b;
      2'b01:   alu_out = ~alu_in_a;
      2'b10:   alu_out = alu_in_a & alu_in_b;
      default: alu_out = 16'h0000;
    endcase
  end

  alu_operate_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr),
    .ext_wr_data(ext_wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_select(alu_select), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .nzp(nzp), .done(done), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_nzp = 3'b010;
    m_a = 16'h0000;
    m_b = 16'h0000;
    m_sel = 2'b00;
  endtask

  task automatic check_reg(input logic [2:0] r);
    dbg_addr = r;
    #1 check($sformatf("reg%0d", r), dbg_data, m_rf[r]);
  endtask

  // Called at a negedge while idle; vld also offers an instruction that the load must beat.
  task automatic load(input logic [2:0] addr, input logic [15:0] data, input bit vld);
    ext_wr_en = 1'b1; ext_wr_addr = addr; ext_wr_data = data;
    instr_valid = vld; instr = 16'h1000;
    #1 check("load_ready_low", instr_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    ext_wr_en = 1'b0; instr_valid = 1'b0;
    m_rf[addr] = data;
    #1 check("load_no_accept", {instr_ready, done, illegal}, 3'b100);
  endtask

  task automatic issue(input logic [15:0] w);
    logic [3:0]  op;
    logic [15:0] a, b, res;
    logic [1:0]  sel;
    logic [2:0]  exp_nzp;
    int          imm;
    bit          legal;
    op = w[15:12];
    legal = (op == 4'd1) || (op == 4'd5) || (op == 4'd9);
    a = m_rf[w[8:6]];
    imm = int'(w[4:0]);
    if (imm >= 16) imm = imm - 32;
    b = w[5] ? 16'(imm) : m_rf[w[2:0]];
    if (op == 4'd9) begin
      b = 16'h0000; sel = 2'b01; res = ~a;
    end else if (op == 4'd5) begin
      sel = 2'b10; res = a & b;
    end else begin
      sel = 2'b00; res = 16'(a + b);
    end
    exp_nzp = (res == 16'h0000) ? 3'b010 : (res >= 16'h8000) ? 3'b100 : 3'b001;

    ext_wr_en = 1'b0; instr = w; instr_valid = 1'b1;
    #1 check("accept_ready", instr_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    instr_valid = $urandom; instr = $urandom;
    ext_wr_en = 1'b1; ext_wr_addr = $urandom; ext_wr_data = $urandom;
    if (!legal) begin
      #1 check("ill_pulse", {illegal, done, instr_ready}, 3'b100);
      @(posedge clk); @(negedge clk);
      ext_wr_en = 1'b0; instr_valid = 1'b0;
      #1 check("ill_end", {illegal, done, instr_ready}, 3'b001);
      check("ill_nzp", nzp, m_nzp);
      check("ill_ops", {alu_select, alu_in_a, alu_in_b}, {m_sel, m_a, m_b});
    end else begin
      #1 check("read_busy", {done, illegal, instr_ready}, 3'b000);
      @(posedge clk); @(negedge clk);
      #1 check("op_a", alu_in_a, a);
      check("op_b", alu_in_b, b);
      check("op_sel", alu_select, sel);
      check("exec_busy", {done, instr_ready}, 2'b00);
      @(posedge clk); @(negedge clk);
      ext_wr_en = 1'b0; instr_valid = 1'b0;
      #1 check("done_pulse", {done, illegal, instr_ready}, 3'b100);
      check("nzp_before_wb", nzp, m_nzp);
      @(posedge clk); @(negedge clk);
      m_rf[w[11:9]] = res; m_nzp = exp_nzp; m_a = a; m_b = b; m_sel = sel;
      #1 check("after_wb", {done, instr_ready}, 2'b01);
      check("nzp", nzp, m_nzp);
      check_reg(w[11:9]);
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < 8; i++) check_reg(3'(i));
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000; ext_wr_en = 1'b0;
    ext_wr_addr = 3'd0; ext_wr_data = 16'h0000; dbg_addr = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check("rst_outs", {done, illegal, instr_ready, nzp}, {3'b001, 3'b010});
    check("rst_ops", {alu_select, alu_in_a, alu_in_b}, 34'h0);
    sweep();
    @(negedge clk);
    rst_n = 1'b1;

    load(3'd2, 16'h0005, 1'b0);
    issue(16'h12BD);
    load(3'd1, 16'h00F0, 1'b0);
    load(3'd2, 16'h0F0F, 1'b0);
    issue(16'h5642);
    load(3'd4, 16'h0001, 1'b0);
    issue(16'h993F);
    load(3'd5, 16'h8000, 1'b0);
    issue(16'h1B45);
    issue(16'h0000);
    sweep();
    load(3'd6, 16'h1234, 1'b1);
    issue(16'h1DA1);

    // Abort during EXEC of ADD R1,R2,#-3
    @(negedge clk);
    load(3'd2, 16'h0005, 1'b0);
    instr = 16'h12BD; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 check("rst_mid_outs", {done, illegal, nzp}, {2'b00, 3'b010});
    check("rst_mid_ops", {alu_select, alu_in_a, alu_in_b}, 34'h0);
    sweep();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("rst_no_done", {done, nzp}, {1'b0, 3'b010});
    end
    check_reg(3'd1);

    for (int n = 0; n < 300; n++) begin
      logic [15:0] w;
      if ($urandom_range(0, 3) == 0) begin
        load(3'($urandom), 16'($urandom), 1'($urandom));
      end else begin
        w = $urandom;
        case ($urandom_range(0, 3))
          0: w[15:12] = 4'b0001;
          1: w[15:12] = 4'b0101;
          2: w[15:12] = 4'b1001;
          default: ;
        endcase
        issue(w);
      end
    end
    sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
